// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchronizer, 3-sample majority voting, parity/frame/break
// detection, and a first-word-fall-through receive FIFO with per-character flags.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int BAUD_W     = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_enable,
    input  logic [3:0]                  i_data_len_limit,
    input  logic                        i_stop_len_limit,
    input  logic                        i_parity_en,
    input  logic                        i_parity_polarity,
    input  logic [BAUD_W-1:0]           i_baud_limit,
    input  logic                        i_rxd,
    input  logic                        i_rx_pop,
    input  logic                        i_rx_flush,
    input  logic                        i_clear_overrun,
    output logic                        o_rx_valid,
    output logic [8:0]                  o_rx_data,
    output logic                        o_rx_parity_err,
    output logic                        o_rx_frame_err,
    output logic                        o_rx_break,
    output logic [$clog2(FIFO_DEPTH):0] o_rx_level,
    output logic                        o_rx_overrun,
    output logic                        o_rx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_PARITY  = 3'd3;
    localparam logic [2:0] S_STOP    = 3'd4;
    localparam logic [2:0] S_PUSH    = 3'd5;
    localparam logic [2:0] S_BRKWAIT = 3'd6;

    // Synchronizer plus two delayed copies that feed the majority vote.
    logic r_rxd_meta, r_rxd_sync, r_rxd_d1, r_rxd_d2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_d1   <= 1'b1;
            r_rxd_d2   <= 1'b1;
        end else begin
            r_rxd_meta <= i_rxd;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_d1   <= r_rxd_sync;
            r_rxd_d2   <= r_rxd_d1;
        end
    end

    logic w_fall, w_bit, w_sampling, w_tick;

    assign w_fall = r_rxd_d1 & ~r_rxd_sync;
    assign w_bit  = (r_rxd_sync & r_rxd_d1) | (r_rxd_sync & r_rxd_d2) | (r_rxd_d1 & r_rxd_d2);

    logic [2:0]        r_state;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [BAUD_W-1:0] r_baud;
    logic [3:0]        r_len;
    logic              r_stop2, r_par_en, r_par_pol;
    logic [3:0]        r_bit_cnt;
    logic [8:0]        r_data;
    logic              r_par, r_all_zero, r_perr, r_ferr, r_brk;

    assign w_sampling = (r_state == S_START) | (r_state == S_DATA) |
                        (r_state == S_PARITY) | (r_state == S_STOP);
    assign w_tick     = w_sampling & (r_baud_cnt == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_baud     <= '0;
            r_len      <= '0;
            r_stop2    <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_pol  <= 1'b0;
            r_bit_cnt  <= '0;
            r_data     <= '0;
            r_par      <= 1'b0;
            r_all_zero <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_brk      <= 1'b0;
        end else begin
            if (w_sampling)
                r_baud_cnt <= (r_baud_cnt == '0) ? r_baud : r_baud_cnt - 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (i_enable && w_fall) begin
                        r_state    <= S_START;
                        r_baud_cnt <= i_baud_limit >> 1;
                        r_baud     <= i_baud_limit;
                        r_len      <= i_data_len_limit;
                        r_stop2    <= i_stop_len_limit;
                        r_par_en   <= i_parity_en;
                        r_par_pol  <= i_parity_polarity;
                        r_bit_cnt  <= '0;
                        r_data     <= '0;
                        r_par      <= 1'b0;
                        r_all_zero <= 1'b1;
                        r_perr     <= 1'b0;
                        r_ferr     <= 1'b0;
                        r_brk      <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_tick)
                        r_state <= w_bit ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_data <= r_data | (9'(w_bit) << r_bit_cnt);
                        r_par  <= r_par ^ w_bit;
                        if (w_bit)
                            r_all_zero <= 1'b0;
                        if (r_bit_cnt == r_len) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_perr <= r_par ^ w_bit ^ r_par_pol;
                        if (w_bit)
                            r_all_zero <= 1'b0;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (!w_bit)
                            r_ferr <= 1'b1;
                        // A break is decided on the first stop sample only.
                        if (r_bit_cnt == '0)
                            r_brk <= r_all_zero & ~w_bit;
                        if (r_bit_cnt == {3'b000, r_stop2})
                            r_state <= S_PUSH;
                        else
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_PUSH: begin
                    r_state <= r_brk ? S_BRKWAIT : S_IDLE;
                end
                S_BRKWAIT: begin
                    if (r_rxd_sync)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_rx_busy = (r_state != S_IDLE);

    // Receive FIFO: entry = {break, frame, parity, data[8:0]}.
    logic [11:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overrun;

    logic          w_push_req, w_full, w_empty, w_do_pop, w_do_push, w_overflow;
    logic [11:0]   w_entry, w_head;

    assign w_push_req = (r_state == S_PUSH);
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_do_pop   = i_rx_pop & ~w_empty & ~i_rx_flush;
    assign w_do_push  = w_push_req & ~i_rx_flush & (~w_full | w_do_pop);
    assign w_overflow = w_push_req & ~i_rx_flush & w_full & ~w_do_pop;
    assign w_entry    = {r_brk, r_ferr, r_perr, r_data};

    // NOTE: storage has no reset; the read side is qualified by the entry count.
    always_ff @(posedge i_clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (i_rx_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_do_push)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_do_pop)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_do_push && !w_do_pop)
                    r_count <= r_count + 1'b1;
                else if (!w_do_push && w_do_pop)
                    r_count <= r_count - 1'b1;
            end
            if (w_overflow)
                r_overrun <= 1'b1;
            else if (i_clear_overrun)
                r_overrun <= 1'b0;
        end
    end

    assign w_head          = w_empty ? 12'h000 : r_mem[r_rd_ptr];
    assign o_rx_valid      = ~w_empty;
    assign o_rx_data       = w_head[8:0];
    assign o_rx_parity_err = w_head[9];
    assign o_rx_frame_err  = w_head[10];
    assign o_rx_break      = w_head[11];
    assign o_rx_level      = r_count;
    assign o_rx_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized frames,
// compared against a queue-based model built from the frame bits that were sent.
module tb_uart_rx_fifo;

    localparam int DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_enable;
    logic [3:0]  i_data_len_limit;
    logic        i_stop_len_limit;
    logic        i_parity_en;
    logic        i_parity_polarity;
    logic [15:0] i_baud_limit;
    logic        i_rxd;
    logic        i_rx_pop;
    logic        i_rx_flush;
    logic        i_clear_overrun;
    logic        o_rx_valid;
    logic [8:0]  o_rx_data;
    logic        o_rx_parity_err;
    logic        o_rx_frame_err;
    logic        o_rx_break;
    logic [2:0]  o_rx_level;
    logic        o_rx_overrun;
    logic        o_rx_busy;

    uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .BAUD_W(16)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_enable          (i_enable),
        .i_data_len_limit  (i_data_len_limit),
        .i_stop_len_limit  (i_stop_len_limit),
        .i_parity_en       (i_parity_en),
        .i_parity_polarity (i_parity_polarity),
        .i_baud_limit      (i_baud_limit),
        .i_rxd             (i_rxd),
        .i_rx_pop          (i_rx_pop),
        .i_rx_flush        (i_rx_flush),
        .i_clear_overrun   (i_clear_overrun),
        .o_rx_valid        (o_rx_valid),
        .o_rx_data         (o_rx_data),
        .o_rx_parity_err   (o_rx_parity_err),
        .o_rx_frame_err    (o_rx_frame_err),
        .o_rx_break        (o_rx_break),
        .o_rx_level        (o_rx_level),
        .o_rx_overrun      (o_rx_overrun),
        .o_rx_busy         (o_rx_busy)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int   rise_cyc = -1;
    logic prev_valid = 1'b0;
    always @(negedge i_clk) begin
        if (o_rx_valid && !prev_valid)
            rise_cyc <= cyc;
        prev_valid <= o_rx_valid;
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: an ideal bounded queue plus a sticky overrun bit.
    logic [11:0] m_q[$];
    bit          m_ovr = 1'b0;

    function automatic void model_push(input logic [11:0] e);
        if (m_q.size() < DEPTH)
            m_q.push_back(e);
        else
            m_ovr = 1'b1;
    endfunction

    function automatic logic [11:0] head_obs();
        return {o_rx_break, o_rx_frame_err, o_rx_parity_err, o_rx_data};
    endfunction

    function automatic int push_cyc(input int nbits, input int baud);
        return 4 + (baud >> 1) + (nbits - 1) * (baud + 1);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic pop_head(input string tag);
        check({tag, "_valid"}, o_rx_valid, 1);
        check({tag, "_head"}, head_obs(), m_q[0]);
        i_rx_pop = 1'b1;
        tick(1);
        i_rx_pop = 1'b0;
        void'(m_q.pop_front());
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (m_q.size() > 0 && guard < 2 * DEPTH) begin
            check({tag, "_lvl"}, o_rx_level, m_q.size());
            pop_head(tag);
            guard++;
        end
        check({tag, "_empty"}, o_rx_valid, 0);
        check({tag, "_lvl0"}, o_rx_level, 0);
    endtask

    // mode: 0 plain, 1 scramble config mid-frame, 2 drop enable mid-frame, 3 enable off.
    task automatic send_frame(input logic [8:0] data, input int nd, input bit pen,
                              input bit ppol, input bit bad_par, input int ns,
                              input bit [1:0] stops, input int baud, input int glitch_bit,
                              input int mode, output logic [11:0] exp_e);
        logic [15:0] bits;
        logic [8:0]  d;
        bit          pb, perr, ferr, brk;
        int          n, len, half;
        d = '0;
        for (int i = 0; i < nd; i++) d[i] = data[i];
        pb   = (^d) ^ ppol ^ bad_par;
        bits = '0;
        n    = 1;
        for (int i = 0; i < nd; i++) begin bits[n] = d[i]; n++; end
        if (pen) begin bits[n] = pb; n++; end
        for (int i = 0; i < ns; i++) begin bits[n] = stops[i]; n++; end
        perr  = pen ? ((^d) ^ pb ^ ppol) : 1'b0;
        ferr  = !stops[0] || (ns == 2 && !stops[1]);
        brk   = (d == 9'd0) && (!pen || !pb) && !stops[0];
        exp_e = {brk, ferr, perr, d};

        i_enable          = (mode != 3);
        i_data_len_limit  = 4'(nd - 1);
        i_stop_len_limit  = (ns == 2);
        i_parity_en       = pen;
        i_parity_polarity = ppol;
        i_baud_limit      = 16'(baud);
        len  = baud + 1;
        half = baud >> 1;
        for (int i = 0; i < n; i++) begin
            i_rxd = bits[i];
            if (i == 0 && (mode == 1 || mode == 2)) begin
                tick(5);
                if (mode == 1) begin
                    i_data_len_limit  = 4'($urandom_range(4, 8));
                    i_stop_len_limit  = 1'($urandom_range(0, 1));
                    i_parity_en       = 1'($urandom_range(0, 1));
                    i_parity_polarity = 1'($urandom_range(0, 1));
                    i_baud_limit      = 16'($urandom_range(7, 300));
                end else begin
                    i_enable = 1'b0;
                end
                tick(len - 5);
            end else if (i == glitch_bit) begin
                tick(half);
                i_rxd = ~bits[i];
                tick(1);
                i_rxd = bits[i];
                tick(len - half - 1);
            end else begin
                tick(len);
            end
        end
        i_rxd = 1'b1;
    endtask

    logic [11:0] e;
    int          t0;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_enable = 1'b1; i_data_len_limit = 4'd7; i_stop_len_limit = 1'b0;
        i_parity_en = 1'b0; i_parity_polarity = 1'b0; i_baud_limit = 16'd129;
        i_rxd = 1'b1; i_rx_pop = 1'b0; i_rx_flush = 1'b0; i_clear_overrun = 1'b0;

        // Reset state.
        tick(3);
        check("rst_valid", o_rx_valid, 0);
        check("rst_data", o_rx_data, 0);
        check("rst_flags", {o_rx_break, o_rx_frame_err, o_rx_parity_err}, 0);
        check("rst_level", o_rx_level, 0);
        check("rst_ovr", o_rx_overrun, 0);
        check("rst_busy", o_rx_busy, 0);
        i_rst = 1'b0;
        tick(4);
        check("post_rst_busy", o_rx_busy, 0);

        // Pop while empty is ignored.
        i_rx_pop = 1'b1; tick(1); i_rx_pop = 1'b0;
        check("pop_empty_lvl", o_rx_level, 0);

        // 8N1 0xA5 with push latency.
        t0 = cyc;
        send_frame(9'h0A5, 8, 0, 0, 0, 1, 2'b11, 129, -1, 0, e);
        model_push(e);
        check("t1_rise", rise_cyc, t0 + push_cyc(10, 129) + 1);
        check("t1_data", o_rx_data, 9'h0A5);
        check("t1_flags", {o_rx_break, o_rx_frame_err, o_rx_parity_err}, 0);
        check("t1_level", o_rx_level, 1);
        drain("t1");

        // 9E2: good parity, bad parity, second stop bit low.
        send_frame(9'h1C3, 9, 1, 0, 0, 2, 2'b11, 31, -1, 0, e); model_push(e);
        send_frame(9'h1C3, 9, 1, 0, 1, 2, 2'b11, 31, -1, 0, e); model_push(e);
        send_frame(9'h1C3, 9, 1, 0, 0, 2, 2'b01, 31, -1, 0, e); model_push(e);
        tick(64);
        check("p_perr0", o_rx_parity_err, 0);
        check("p_data", o_rx_data, 9'h1C3);
        drain("par");

        // False starts and majority-masked glitch.
        i_baud_limit = 16'd129; i_data_len_limit = 4'd7; i_parity_en = 1'b0;
        i_stop_len_limit = 1'b0; i_enable = 1'b1;
        i_rxd = 1'b0; tick(2); i_rxd = 1'b1;
        tick(10);
        check("gl2_busy1", o_rx_busy, 1);
        tick(130);
        check("gl2_busy0", o_rx_busy, 0);
        check("gl2_lvl", o_rx_level, 0);
        i_rxd = 1'b0; tick(63); i_rxd = 1'b1;
        check("ghalf_busy1", o_rx_busy, 1);
        tick(130);
        check("ghalf_busy0", o_rx_busy, 0);
        check("ghalf_lvl", o_rx_level, 0);
        send_frame(9'h03C, 8, 0, 0, 0, 1, 2'b11, 129, 3, 0, e); model_push(e);
        tick(10);
        check("maj_data", o_rx_data, 9'h03C);
        drain("maj");

        // Break: line low for two frame times.
        i_rxd = 1'b0;
        tick(20 * 130);
        model_push({1'b1, 1'b1, 1'b0, 9'h000});
        check("brk_lvl", o_rx_level, m_q.size());
        check("brk_busy", o_rx_busy, 1);
        check("brk_head", head_obs(), 12'hC00);
        i_rxd = 1'b1;
        tick(260);
        check("brk_idle", o_rx_busy, 0);
        check("brk_lvl2", o_rx_level, 1);
        send_frame(9'h055, 8, 0, 0, 0, 1, 2'b11, 129, -1, 0, e); model_push(e);
        drain("brk");

        // Overflow with depth 4.
        for (int k = 0; k < 6; k++) begin
            send_frame(9'($urandom), 8, 0, 0, 0, 1, 2'b11, 15, -1, 0, e);
            model_push(e);
            tick(8);
        end
        check("ovf_lvl", o_rx_level, 4);
        check("ovf_flag", o_rx_overrun, m_ovr);
        i_clear_overrun = 1'b1; tick(1); i_clear_overrun = 1'b0; m_ovr = 1'b0;
        check("ovf_clr", o_rx_overrun, 0);

        // Pop in the push cycle of a full FIFO.
        t0 = cyc;
        fork
            send_frame(9'h0E7, 8, 0, 0, 0, 1, 2'b11, 15, -1, 0, e);
            begin
                while (cyc < t0 + push_cyc(10, 15)) tick(1);
                i_rx_pop = 1'b1; tick(1); i_rx_pop = 1'b0;
            end
        join
        void'(m_q.pop_front());
        m_q.push_back(e);
        tick(8);
        check("pp_lvl", o_rx_level, 4);
        check("pp_ovr", o_rx_overrun, 0);
        drain("pp");

        // Flush coinciding with a push into a full FIFO.
        for (int k = 0; k < 4; k++) begin
            send_frame(9'($urandom), 8, 0, 0, 0, 1, 2'b11, 15, -1, 0, e);
            model_push(e);
            tick(8);
        end
        check("fl_pre", o_rx_level, 4);
        t0 = cyc;
        fork
            send_frame(9'h011, 8, 0, 0, 0, 1, 2'b11, 15, -1, 0, e);
            begin
                while (cyc < t0 + push_cyc(10, 15)) tick(1);
                i_rx_flush = 1'b1; tick(1); i_rx_flush = 1'b0;
            end
        join
        m_q.delete();
        tick(8);
        check("fl_lvl", o_rx_level, 0);
        check("fl_valid", o_rx_valid, 0);
        check("fl_ovr", o_rx_overrun, 0);

        // Enable dropped mid-frame completes; disabled line is ignored.
        send_frame(9'h0C9, 8, 0, 0, 0, 1, 2'b11, 15, -1, 2, e); model_push(e);
        tick(8);
        check("en_drop_lvl", o_rx_level, 1);
        send_frame(9'h012, 8, 0, 0, 0, 1, 2'b11, 15, -1, 3, e);
        tick(8);
        check("en_off_lvl", o_rx_level, 1);
        i_enable = 1'b1;
        drain("en");

        // Reset mid-data-bit with entries and overrun pending.
        for (int k = 0; k < 5; k++) begin
            send_frame(9'($urandom), 8, 0, 0, 0, 1, 2'b11, 15, -1, 0, e);
            model_push(e);
            tick(8);
        end
        check("rm_ovr_pre", o_rx_overrun, m_ovr);
        i_rxd = 1'b0;
        tick(24);
        check("rm_busy_pre", o_rx_busy, 1);
        i_rst = 1'b1;
        #2;
        check("rm_valid", o_rx_valid, 0);
        check("rm_data", o_rx_data, 0);
        check("rm_flags", {o_rx_break, o_rx_frame_err, o_rx_parity_err}, 0);
        check("rm_lvl", o_rx_level, 0);
        check("rm_ovr", o_rx_overrun, 0);
        check("rm_busy", o_rx_busy, 0);
        m_q.delete(); m_ovr = 1'b0;
        i_rxd = 1'b1;
        tick(3);
        i_rst = 1'b0;
        tick(3);
        send_frame(9'h05A, 8, 0, 0, 0, 1, 2'b11, 15, -1, 0, e); model_push(e);
        drain("rm");

        // Randomized frames with mid-frame config changes and random draining.
        for (int k = 0; k < 24; k++) begin
            int nd, ns, baud, r, gb;
            bit pen, pol, bad;
            bit [1:0] stops;
            logic [8:0] d;
            nd    = $urandom_range(5, 9);
            ns    = $urandom_range(1, 2);
            baud  = $urandom_range(7, 40);
            pen   = 1'($urandom_range(0, 1));
            pol   = 1'($urandom_range(0, 1));
            d     = 9'($urandom);
            bad   = 1'b0;
            stops = 2'b11;
            gb    = -1;
            r     = $urandom_range(0, 7);
            if (r == 0) bad = 1'b1;
            else if (r == 1) stops = 2'($urandom_range(0, 2));
            else if (r == 2) begin d = '0; bad = pol; stops[0] = 1'b0; end
            else if (r == 3) gb = $urandom_range(1, nd);
            send_frame(d, nd, pen, pol, bad, ns, stops, baud, gb, 1, e);
            model_push(e);
            tick(2 * (baud + 1));
            check($sformatf("rnd%0d_lvl", k), o_rx_level, m_q.size());
            check($sformatf("rnd%0d_ovr", k), o_rx_overrun, m_ovr);
            if ($urandom_range(0, 1) == 1 && m_q.size() > 0)
                pop_head($sformatf("rnd%0d_pop", k));
            if ($urandom_range(0, 5) == 0) begin
                i_clear_overrun = 1'b1; tick(1); i_clear_overrun = 1'b0;
                m_ovr = 1'b0;
            end
        end
        drain("rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
